// File: rtl/key_cmd_scheduler.sv
// Purpose : maps keyboard make/break events to game commands, auto-repeats a held
//           jump key, and queues commands in a 4-entry FIFO for a consumer.
// Latency : a mapped event reaches the FIFO head 1 cycle after its key_valid cycle.
// Backpr. : cmd_valid/cmd_ready handshake; a push into a full FIFO with no pop is
//           dropped and flagged by a 1-cycle overflow pulse.
// Ports   : clock, rst (async, active-high)
//           key_valid, last_change[8:0], key_down[511:0]  - keyboard event input
//           cmd_valid, cmd[2:0], cmd_ready                 - command output handshake
//           fifo_count[2:0], overflow                      - status
module key_cmd_scheduler #(
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000
) (
    input  logic         clock,
    input  logic         rst,
    input  logic         key_valid,
    input  logic [8:0]   last_change,
    input  logic [511:0] key_down,
    output logic         cmd_valid,
    output logic [2:0]   cmd,
    input  logic         cmd_ready,
    output logic [2:0]   fifo_count,
    output logic         overflow
);

    localparam logic [2:0] CMD_NONE     = 3'd0;
    localparam logic [2:0] CMD_JUMP     = 3'd1;
    localparam logic [2:0] CMD_DUCK_ON  = 3'd2;
    localparam logic [2:0] CMD_DUCK_OFF = 3'd3;
    localparam logic [2:0] CMD_START    = 3'd4;
    localparam logic [2:0] CMD_PAUSE    = 3'd5;

    localparam logic [24:0] DELAY_LAST  = 25'(REPEAT_DELAY - 1);
    localparam logic [24:0] PERIOD_LAST = 25'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {R_IDLE, R_DELAY, R_REPEAT} rstate_t;

    rstate_t     state;
    logic [24:0] cnt;

    logic [2:0] mem [4];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] count_q;
    logic       overflow_q;

    logic       is_make;
    logic       jump_make;
    logic       jump_held;
    logic       rep_req;
    logic [2:0] ev_cmd;
    logic [2:0] push_cmd;
    logic       push;
    logic       pop;
    logic       full;
    logic       wr_en;

    // key_down already reflects this event, so the addressed bit tells make from break.
    assign is_make   = key_down[last_change];
    assign jump_held = key_down[9'h029] | key_down[9'h175];

    always_comb begin
        ev_cmd    = CMD_NONE;
        jump_make = 1'b0;
        if (key_valid) begin
            if (is_make && (last_change == 9'h029 || last_change == 9'h175)) begin
                ev_cmd    = CMD_JUMP;
                jump_make = 1'b1;
            end else if (last_change == 9'h072 || last_change == 9'h172) begin
                ev_cmd = is_make ? CMD_DUCK_ON : CMD_DUCK_OFF;
            end else if (is_make && last_change == 9'h05A) begin
                ev_cmd = CMD_START;
            end else if (is_make && last_change == 9'h076) begin
                ev_cmd = CMD_PAUSE;
            end
        end
    end

    // A release of both jump keys suppresses the request in the same cycle.
    assign rep_req = jump_held &&
                     ((state == R_DELAY  && cnt == DELAY_LAST) ||
                      (state == R_REPEAT && cnt == PERIOD_LAST));

    // A real key event wins over a coincident repeat; the repeat is silently lost.
    assign push_cmd = (ev_cmd != CMD_NONE) ? ev_cmd : (rep_req ? CMD_JUMP : CMD_NONE);
    assign push     = (push_cmd != CMD_NONE);
    assign full     = (count_q == 3'd4);
    assign pop      = cmd_ready && (count_q != 3'd0);
    assign wr_en    = push && (!full || pop);

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state <= R_IDLE;
            cnt   <= '0;
        end else if (jump_make) begin
            state <= R_DELAY;
            cnt   <= '0;
        end else begin
            case (state)
                R_DELAY: begin
                    if (!jump_held) begin
                        state <= R_IDLE;
                        cnt   <= '0;
                    end else if (cnt == DELAY_LAST) begin
                        state <= R_REPEAT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 25'd1;
                    end
                end
                R_REPEAT: begin
                    if (!jump_held) begin
                        state <= R_IDLE;
                        cnt   <= '0;
                    end else if (cnt == PERIOD_LAST) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 25'd1;
                    end
                end
                default: begin
                    state <= R_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                mem[i] <= CMD_NONE;
            end
            wr_ptr     <= 2'd0;
            rd_ptr     <= 2'd0;
            count_q    <= 3'd0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= push && full && !pop;
            if (wr_en) begin
                mem[wr_ptr] <= push_cmd;
                wr_ptr      <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({wr_en, pop})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign cmd_valid  = (count_q != 3'd0);
    assign cmd        = cmd_valid ? mem[rd_ptr] : CMD_NONE;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_key_cmd_scheduler.sv
// Purpose : self-checking bench for key_cmd_scheduler (REPEAT_DELAY=8, REPEAT_PERIOD=4).
// Latency : model predicts registered outputs one cycle after each input cycle.
// Backpr. : cmd_ready driven directly by directed scenarios and random stimulus.
module tb_key_cmd_scheduler;

    localparam int RD = 8;
    localparam int RP = 4;

    logic         clock = 1'b0;
    logic         rst;
    logic         key_valid;
    logic [8:0]   last_change;
    logic [511:0] key_down;
    logic         cmd_valid;
    logic [2:0]   cmd;
    logic         cmd_ready;
    logic [2:0]   fifo_count;
    logic         overflow;

    int tests = 0;
    int fails = 0;

    key_cmd_scheduler #(.REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
        .clock      (clock),
        .rst        (rst),
        .key_valid  (key_valid),
        .last_change(last_change),
        .key_down   (key_down),
        .cmd_valid  (cmd_valid),
        .cmd        (cmd),
        .cmd_ready  (cmd_ready),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a command queue plus the time of the last jump make.
    // Repeats fall due at make+RD, make+RD+RP, ... while a jump key stays held.
    int  q[$];
    int  exp_ovf = 0;
    bit  active  = 0;
    int  t0      = 0;
    int  cyc     = 0;

    always @(negedge clock) begin
        if (rst) begin
            q.delete();
            exp_ovf = 0;
            active  = 0;
            chk("rst_valid", int'(cmd_valid), 0);
            chk("rst_count", int'(fifo_count), 0);
            chk("rst_cmd", int'(cmd), 0);
            chk("rst_ovf", int'(overflow), 0);
        end else begin
            int  ev;
            bit  mk;
            bit  req;
            int  pc;
            int  d;
            chk("m_valid", int'(cmd_valid), (q.size() != 0) ? 1 : 0);
            chk("m_cmd", int'(cmd), (q.size() != 0) ? q[0] : 0);
            chk("m_count", int'(fifo_count), q.size());
            chk("m_ovf", int'(overflow), exp_ovf);

            ev  = 0;
            req = 0;
            mk  = key_down[last_change];
            if (key_valid) begin
                case (last_change)
                    9'h029, 9'h175: ev = mk ? 1 : 0;
                    9'h072, 9'h172: ev = mk ? 2 : 3;
                    9'h05A:         ev = mk ? 4 : 0;
                    9'h076:         ev = mk ? 5 : 0;
                    default:        ev = 0;
                endcase
            end
            if (ev == 1) begin
                active = 1;
                t0     = cyc;
            end else if (active) begin
                if (!key_down[9'h029] && !key_down[9'h175]) begin
                    active = 0;
                end else begin
                    d = cyc - t0;
                    if (d >= RD && ((d - RD) % RP) == 0) req = 1;
                end
            end
            pc = (ev != 0) ? ev : (req ? 1 : 0);
            exp_ovf = 0;
            if (cmd_ready && q.size() != 0) void'(q.pop_front());
            if (pc != 0) begin
                if (q.size() == 4) exp_ovf = 1;
                else q.push_back(pc);
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic press(input logic [8:0] code, input bit mk);
        key_down[code] = mk;
        last_change    = code;
        key_valid      = 1'b1;
        tick();
    endtask

    logic [8:0] codes [8];

    initial begin
        codes = '{9'h029, 9'h175, 9'h072, 9'h172, 9'h05A, 9'h076, 9'h01C, 9'h074};
        rst = 1'b1;
        key_valid = 1'b0;
        last_change = '0;
        key_down = '0;
        cmd_ready = 1'b0;
        repeat (3) tick();
        chk("reset_valid", int'(cmd_valid), 0);
        chk("reset_count", int'(fifo_count), 0);
        rst = 1'b0;
        tick();

        // First event after reset: space make, consumer stalled.
        press(9'h029, 1'b1);
        chk("jump_valid", int'(cmd_valid), 1);
        chk("jump_cmd", int'(cmd), 1);
        chk("jump_count", int'(fifo_count), 1);
        press(9'h029, 1'b0);
        chk("jump_release_count", int'(fifo_count), 1);
        cmd_ready = 1'b1;
        tick();
        chk("jump_drain", int'(fifo_count), 0);

        // Duck make then break, consumer always ready.
        press(9'h072, 1'b1);
        chk("duck_on_cmd", int'(cmd), 2);
        chk("duck_on_count", int'(fifo_count), 1);
        press(9'h072, 1'b0);
        chk("duck_off_cmd", int'(cmd), 3);
        chk("duck_off_count", int'(fifo_count), 1);
        tick();
        chk("duck_drain", int'(fifo_count), 0);

        // Space held 20 cycles: heads visible in cycles 1, 9, 13, 17 after the make.
        press(9'h029, 1'b1);
        for (int c = 1; c < 20; c++) begin
            chk($sformatf("rep_c%0d", c), int'(cmd_valid),
                (c == 1 || c == 9 || c == 13 || c == 17) ? 1 : 0);
            tick();
        end
        press(9'h029, 1'b0);
        for (int c = 21; c < 32; c++) begin
            chk($sformatf("rep_after_c%0d", c), int'(cmd_valid), 0);
            tick();
        end

        // Five enter makes into a stalled FIFO.
        cmd_ready = 1'b0;
        repeat (4) press(9'h05A, 1'b1);
        chk("full_count", int'(fifo_count), 4);
        chk("full_ovf0", int'(overflow), 0);
        press(9'h05A, 1'b1);
        chk("ovf_pulse", int'(overflow), 1);
        chk("ovf_count", int'(fifo_count), 4);
        chk("ovf_head", int'(cmd), 4);
        tick();
        chk("ovf_gone", int'(overflow), 0);
        cmd_ready = 1'b1;
        press(9'h05A, 1'b1);
        chk("pushpop_count", int'(fifo_count), 4);
        chk("pushpop_ovf", int'(overflow), 0);
        press(9'h05A, 1'b0);
        repeat (5) tick();
        chk("full_drain", int'(fifo_count), 0);

        // Reset with three queued and repeat running.
        cmd_ready = 1'b0;
        press(9'h029, 1'b1);
        press(9'h05A, 1'b1);
        press(9'h076, 1'b1);
        repeat (3) tick();
        chk("pre_rst_count", int'(fifo_count), 3);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", int'(cmd_valid), 0);
        chk("async_rst_count", int'(fifo_count), 0);
        chk("async_rst_cmd", int'(cmd), 0);
        tick();
        tick();
        rst = 1'b0;
        repeat (14) tick();
        chk("post_rst_nojump", int'(fifo_count), 0);
        cmd_ready = 1'b1;
        press(9'h029, 1'b0);
        press(9'h05A, 1'b0);
        press(9'h076, 1'b0);
        repeat (3) tick();
        chk("post_rst_drain", int'(fifo_count), 0);

        // Esc make lands on the cycle a repeat falls due.
        cmd_ready = 1'b0;
        press(9'h029, 1'b1);
        repeat (7) tick();
        press(9'h076, 1'b1);
        chk("coinc_count", int'(fifo_count), 2);
        chk("coinc_head", int'(cmd), 1);
        chk("coinc_ovf", int'(overflow), 0);
        repeat (4) tick();
        chk("coinc_next_rep", int'(fifo_count), 3);
        cmd_ready = 1'b1;
        tick();
        chk("coinc_second", int'(cmd), 5);
        press(9'h029, 1'b0);
        press(9'h076, 1'b0);
        repeat (5) tick();
        chk("coinc_drain", int'(fifo_count), 0);

        // Randomised traffic, checked cycle by cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1200) begin
                rst = 1'b1;
                tick();
                tick();
                rst = 1'b0;
            end
            cmd_ready = (i < 1500) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) begin
                logic [8:0] code;
                code = codes[$urandom_range(0, 7)];
                press(code, 1'($urandom_range(0, 1)));
            end else begin
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/key_cmd_scheduler.md
KEY_CMD_SCHEDULER -- requirements
Module: key_cmd_scheduler

Interface
REQ-001 Parameters (name, default, meaning) SHALL be: REPEAT_DELAY, 25_000_000, clock cycles from jump-key make to first auto-repeat; REPEAT_PERIOD, 5_000_000, clock cycles between later auto-repeats; both >= 2.
REQ-002 Ports (name direction width meaning) SHALL be: clock in 1 system clock; rst in 1 reset.
REQ-003 Reset rst SHALL be asynchronous, active-high; the clock SHALL be clock.
REQ-004 key_valid in 1: one-cycle pulse marking a keyboard make/break event.
REQ-005 last_change in 9: {extend, scancode} of the event; valid only while key_valid=1.
REQ-006 key_down in 512: per-key held state, already updated in the key_valid cycle.
REQ-007 cmd_valid out 1: a command is available at the FIFO head.
REQ-008 cmd out 3: head command: 1 JUMP, 2 DUCK_ON, 3 DUCK_OFF, 4 START, 5 PAUSE; 0 when empty.
REQ-009 cmd_ready in 1: consumer accepts the head when high together with cmd_valid.
REQ-010 fifo_count out 3: current occupancy, 0..4.
REQ-011 overflow out 1: one-cycle pulse when a command is dropped.

Function
REQ-012 Make/break SHALL be key_down[last_change] in the key_valid cycle: 1 = make, 0 = break.
REQ-013 Mapping SHALL be: make 9'h029 (space) or 9'h175 (up) -> JUMP; make 9'h072 or 9'h172 (down) -> DUCK_ON; break of either down code -> DUCK_OFF; make 9'h05A (enter) -> START; make 9'h076 (esc) -> PAUSE; all other events ignored.
REQ-014 A mapped key event SHALL be pushed on the clock edge ending its key_valid cycle, i.e. visible at the head 1 cycle later if the FIFO was empty.
REQ-015 FIFO SHALL be 4 entries, first-in first-out, 2-bit read/write pointers wrapping 3->0.
REQ-016 Pop SHALL occur on each edge where cmd_valid=1 and cmd_ready=1; cmd_valid SHALL equal (fifo_count!=0).
REQ-017 Push and pop in the same cycle SHALL both take effect, including when full (count unchanged); pop on empty SHALL be ignored.
REQ-018 Push when full without a simultaneous pop SHALL drop the new command, leave FIFO unchanged and pulse overflow for 1 cycle.
REQ-019 Auto-repeat FSM states SHALL be R_IDLE, R_DELAY, R_REPEAT, with a 25-bit counter cnt.
REQ-020 Any JUMP make SHALL set state R_DELAY and cnt=0, from any state, including restart of an in-progress delay.
REQ-021 In R_DELAY, cnt increments; when cnt=REPEAT_DELAY-1 a JUMP SHALL be requested, cnt cleared, state R_REPEAT.
REQ-022 In R_REPEAT, cnt increments; when cnt=REPEAT_PERIOD-1 a JUMP SHALL be requested and cnt cleared.
REQ-023 In R_DELAY or R_REPEAT, if key_down[9'h029] and key_down[9'h175] are both 0, the FSM SHALL go to R_IDLE, cnt=0, with no request that cycle.
REQ-024 When a mapped key event and a repeat request coincide, the key event SHALL be pushed and the repeat request discarded without overflow; the repeat timing is unaffected.
REQ-025 A repeat request with FIFO full and no pop SHALL be dropped with an overflow pulse.

Reset
REQ-026 On rst: FIFO empty, pointers 0, fifo_count=0, cmd_valid=0, cmd=0, overflow=0, FSM R_IDLE, cnt=0; contents discarded even mid-repeat or mid-handshake.
REQ-027 The first key_valid after rst release SHALL be processed normally.

Verification (REPEAT_DELAY=8, REPEAT_PERIOD=4 for benches)
REQ-028 key_valid, last_change=9'h029, key_down[41]=1, cmd_ready=0 -> next cycle cmd_valid=1, cmd=1, fifo_count=1.
REQ-029 Down make then down break, cmd_ready=1 -> cmd=2 then cmd=3 in order; fifo_count returns to 0.
REQ-030 Space held 20 cycles after make, cmd_ready=1 -> JUMPs pushed at make, make+8, make+12, make+16; none after release.
REQ-031 Five enter makes, cmd_ready=0 -> fifo_count=4, overflow pulses once on the fifth; head cmd=4; pop with a push on the same cycle at count 4 -> count stays 4, no overflow.
REQ-032 rst asserted with 3 entries queued and repeat active -> cmd_valid=0, fifo_count=0 immediately; no JUMP after release.
REQ-033 Esc make coinciding with a repeat request -> only PAUSE (5) pushed, overflow=0.
